mantissa_addsub_pipe: RTL and testbench
=======================================

// Module: mantissa_addsub_pipe
// PURPOSE
//  Pipelined, parametrised mantissa add/subtract stage of the FP adder datapath.
//  Sits between the alignment block and the normaliser. It adds or subtracts the
//  aligned (small) mantissa and the big mantissa, and returns magnitude, sign and zero flag.
//  Subtraction handles a negative difference, which the earlier combinational stage did not.
//  Uses a 2-stage valid/ready pipeline with full throughput and backpressure.
// PARAMETERS
//  MAN_W  11  big-mantissa width incl. hidden bit (11 = half, 24 = single)
//  GRS_W  3   guard/round/sticky bits appended below the big mantissa
//  derived: AL_W = MAN_W+GRS_W (aligned width); RES_W = AL_W+1 (result width)
// PORTS
//  clk           in   1      rising-edge clock
//  rst_n         in   1      asynchronous active-low reset
//  in_valid      in   1      input beat present
//  in_ready      out  1      block accepts beat this cycle
//  aligned_man   in   AL_W   aligned small mantissa incl. GRS
//  big_man       in   MAN_W  big mantissa
//  big_sign      in   1      sign of the big operand
//  op_int        in   1      operation from sign compare
//  op_final      in   1      requested operation (0 add, 1 sub)
//  out_valid     out  1      result beat present
//  out_ready     in   1      downstream accepts result
//  res_man       out  RES_W  result magnitude; MSB = add carry-out
//  res_sign      out  1      result sign
//  res_zero      out  1      result magnitude == 0
//  res_lzc       out  $clog2(RES_W+1)  leading-zero count (only with MANT_LZC_EN)
// BEHAVIOUR
//  - Reset (async, rst_n=0): both stage valids=0, out_valid=0, res_man=0, res_sign=0,
//    res_zero=0, res_lzc=0; in_ready=1 from the first cycle after release.
//  - Handshake: a beat transfers when valid&&ready.
//    adv2 = ~s2_valid | out_ready; adv1 = ~s1_valid | adv2; in_ready = adv1 (comb).
//    out_* hold stable while out_valid && !out_ready. No drop, no duplication, order kept.
//  - Stage 1 (on accept): register aligned_man, big_man, big_sign, eff_op = op_int ^ op_final.
//  - Stage 2 (on adv2 with s1_valid): B = {1'b0, big_man, GRS_W'b0}, A = {1'b0, aligned_man}.
//      eff_op=0: res_man = B + A (carry lands in MSB); res_sign = big_sign.
//      eff_op=1: D = B - A in RES_W+1 bits. If D negative: res_man = A - B, res_sign = ~big_sign.
//      Otherwise res_man = D[RES_W-1:0], res_sign = big_sign. MSB is always 0 on subtract.
//    res_zero = (res_man == 0). A zero result forces res_sign = 0.
//  - Latency: 2 cycles from in accept to out_valid (no stall). Throughput: 1 beat/cycle.
//  - Stage 2 empty with adv2: s2_valid clears and data regs hold their old value (don't-care).
//  - Simultaneous accept and drain: both stages advance in the same cycle, with no bubble.
//  - Reset mid-operation: in-flight beats are discarded and no out_valid appears after release.
// CONFIGURATION
//  MANT_LZC_EN defined: stage 2 also registers res_lzc = number of leading zeros of
//    res_man over RES_W bits (RES_W when zero). Used by the normaliser to shift directly.
//  MANT_LZC_EN undefined: port res_lzc absent, and no LZC logic is built.
//  Sum/sign/zero behaviour and latency are identical in both builds.
// TESTING (MAN_W=11, GRS_W=3, RES_W=15)
//  1 add: big=0x400, al=0x2000, op=0/0 -> res_man=0x4000, sign=big_sign, zero=0, lzc=0, 2 cycles later
//  2 sub pos: big=0x400, al=0x1000, op_final=1 -> res_man=0x1000, sign=big_sign, lzc=2
//  3 sub neg: big=0x400, al=0x3000, op_int=1,op_final=0, big_sign=0 -> res_man=0x1000, res_sign=1
//  4 cancel: big=0x400, al=0x2000, sub -> res_man=0, res_zero=1, res_sign=0, lzc=15
//  5 backpressure: 4 beats back-to-back, out_ready=0 for 3 cycles -> in_ready=0 after 2 held;
//    all 4 results emerge in order, no loss; then 1 beat/cycle
//  6 reset: pull rst_n low with 2 beats in flight -> outputs zero at once; no stale out_valid after release

Source files
------------

// File: rtl/mantissa_addsub_pipe.sv
// mantissa_addsub_pipe: two-stage valid/ready add/subtract of the big mantissa
// and the aligned small mantissa. It returns the result magnitude, the sign and
// a zero flag. An optional leading-zero count is built only when MANT_LZC_EN is
// defined.
//
// Handshake: a beat moves across a boundary when its valid and ready are both
// high at a rising edge. A stage may load when it is empty or when its
// contents leave in the same cycle. This gives full throughput with no bubbles.
// While out_valid is high and out_ready is low, all out_* values hold steady.
module mantissa_addsub_pipe #(
  parameter int MAN_W = 11,
  parameter int GRS_W = 3
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           in_valid,
  output logic                           in_ready,
  input  logic [MAN_W+GRS_W-1:0]         aligned_man,
  input  logic [MAN_W-1:0]               big_man,
  input  logic                           big_sign,
  input  logic                           op_int,
  input  logic                           op_final,
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic [MAN_W+GRS_W:0]           res_man,
  output logic                           res_sign,
  output logic                           res_zero
`ifdef MANT_LZC_EN
  ,
  output logic [$clog2(MAN_W+GRS_W+2)-1:0] res_lzc
`endif
);

  localparam int AL_W  = MAN_W + GRS_W;
  localparam int RES_W = AL_W + 1;
  localparam int LZC_W = $clog2(RES_W + 1);

  // Stage 1 registers
  logic             r_s1_valid;
  logic [AL_W-1:0]  r_s1_al;
  logic [MAN_W-1:0] r_s1_big;
  logic             r_s1_sign;
  logic             r_s1_eff_op;

  // Stage 2 registers (these drive the outputs directly)
  logic             r_s2_valid;
  logic [RES_W-1:0] r_s2_man;
  logic             r_s2_sign;
  logic             r_s2_zero;

  logic             w_adv1;
  logic             w_adv2;
  logic [RES_W-1:0] w_b;
  logic [RES_W-1:0] w_a;
  logic [RES_W-1:0] w_sum;
  logic [RES_W:0]   w_diff;
  logic             w_neg;
  logic [RES_W-1:0] w_res_man;
  logic             w_res_zero;
  logic             w_res_sign;

  assign w_adv2   = ~r_s2_valid | out_ready;
  assign w_adv1   = ~r_s1_valid | w_adv2;
  assign in_ready = w_adv1;

  // Stage 1: capture the operands and fold the two op bits into one effective op
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1_valid  <= 1'b0;
      r_s1_al     <= '0;
      r_s1_big    <= '0;
      r_s1_sign   <= 1'b0;
      r_s1_eff_op <= 1'b0;
    end else if (w_adv1) begin
      r_s1_valid <= in_valid;
      if (in_valid) begin
        r_s1_al     <= aligned_man;
        r_s1_big    <= big_man;
        r_s1_sign   <= big_sign;
        r_s1_eff_op <= op_int ^ op_final;
      end
    end
  end

  // Add or subtract the mantissas; a negative difference is flipped to a magnitude
  always_comb begin
    w_b        = {1'b0, r_s1_big, {GRS_W{1'b0}}};
    w_a        = {1'b0, r_s1_al};
    w_sum      = w_b + w_a;
    w_diff     = {1'b0, w_b} - {1'b0, w_a};
    w_neg      = w_diff[RES_W];
    w_res_man  = w_sum;
    w_res_sign = r_s1_sign;
    if (r_s1_eff_op) begin
      if (w_neg) begin
        w_res_man  = w_a - w_b;
        w_res_sign = ~r_s1_sign;
      end else begin
        w_res_man  = w_diff[RES_W-1:0];
      end
    end
    w_res_zero = (w_res_man == '0);
    if (w_res_zero) w_res_sign = 1'b0;
  end

  // Stage 2: register the result; data holds when stage 1 is empty
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s2_valid <= 1'b0;
      r_s2_man   <= '0;
      r_s2_sign  <= 1'b0;
      r_s2_zero  <= 1'b0;
    end else if (w_adv2) begin
      r_s2_valid <= r_s1_valid;
      if (r_s1_valid) begin
        r_s2_man  <= w_res_man;
        r_s2_sign <= w_res_sign;
        r_s2_zero <= w_res_zero;
      end
    end
  end

`ifdef MANT_LZC_EN
  logic [LZC_W-1:0] w_lzc;
  logic [LZC_W-1:0] r_s2_lzc;

  // Leading-zero count of the result; gives RES_W for a zero result
  always_comb begin
    w_lzc = LZC_W'(RES_W);
    for (int i = 0; i < RES_W; i++) begin
      if (w_res_man[i]) w_lzc = LZC_W'(RES_W - 1 - i);
    end
  end

  // Register the count alongside the stage-2 result
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s2_lzc <= '0;
    end else if (w_adv2 && r_s1_valid) begin
      r_s2_lzc <= w_lzc;
    end
  end

  assign res_lzc = r_s2_lzc;
`endif

  assign out_valid = r_s2_valid;
  assign res_man   = r_s2_man;
  assign res_sign  = r_s2_sign;
  assign res_zero  = r_s2_zero;

endmodule

// File: tb/tb_mantissa_addsub_pipe.sv
// tb_mantissa_addsub_pipe: directed and randomized checks of the mantissa
// add/subtract pipeline against an arithmetic reference model.
module tb_mantissa_addsub_pipe;

  localparam int MAN_W = 11;
  localparam int GRS_W = 3;
  localparam int AL_W  = MAN_W + GRS_W;
  localparam int RES_W = AL_W + 1;
  localparam int LZC_W = $clog2(RES_W + 1);

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [AL_W-1:0]  aligned_man = '0;
  logic [MAN_W-1:0] big_man = '0;
  logic             big_sign = 1'b0;
  logic             op_int = 1'b0;
  logic             op_final = 1'b0;
  logic             out_valid;
  logic             out_ready = 1'b0;
  logic [RES_W-1:0] res_man;
  logic             res_sign;
  logic             res_zero;
`ifdef MANT_LZC_EN
  logic [LZC_W-1:0] res_lzc;
`endif

  mantissa_addsub_pipe #(.MAN_W(MAN_W), .GRS_W(GRS_W)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .aligned_man (aligned_man),
    .big_man     (big_man),
    .big_sign    (big_sign),
    .op_int      (op_int),
    .op_final    (op_final),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .res_man     (res_man),
    .res_sign    (res_sign),
    .res_zero    (res_zero)
`ifdef MANT_LZC_EN
    ,
    .res_lzc     (res_lzc)
`endif
  );

  // ---------------- scoreboard ----------------
  // Expected entry packing: {lzc[3:0], zero, sign, man[14:0]}
  logic [20:0] exp_q[$];
  int          n_checks = 0;
  int          n_errors = 0;
  logic        prev_stall = 1'b0;
  logic [17:0] prev_out = '0;
  logic        last_in_ready = 1'b0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference model: plain integer arithmetic on the scaled operands
  function automatic logic [20:0] model(input int al, input int big, input bit bs,
                                        input bit opi, input bit opf);
    int b;
    int mag;
    bit s;
    int lzc;
    b = big * (1 << GRS_W);
    if ((opi ^ opf) == 1'b0) begin
      mag = b + al;
      s   = bs;
    end else if (b >= al) begin
      mag = b - al;
      s   = bs;
    end else begin
      mag = al - b;
      s   = !bs;
    end
    if (mag == 0) s = 1'b0;
    lzc = RES_W;
    for (int i = 0; i < RES_W; i++) begin
      if (((mag >> i) & 1) == 1) lzc = RES_W - 1 - i;
    end
    return {lzc[3:0], (mag == 0), s, mag[14:0]};
  endfunction

  // One clock cycle. Entry and exit are just after a falling edge. The inputs
  // set by the caller apply at the next rising edge.
  task automatic step(output bit acc);
    logic [20:0] e;
    #1;
    if (prev_stall) check("hold_stable", {out_valid, res_sign, res_zero, res_man}, prev_out);
    if (out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        check("unexpected_out", 32'd1, 32'd0);
      end else begin
        e = exp_q.pop_front();
        check("res_man", 32'(res_man), 32'(e[14:0]));
        check("res_sign", 32'(res_sign), 32'(e[15]));
        check("res_zero", 32'(res_zero), 32'(e[16]));
`ifdef MANT_LZC_EN
        check("res_lzc", 32'(res_lzc), 32'(e[20:17]));
`endif
      end
    end
    prev_stall    = out_valid && !out_ready;
    prev_out      = {out_valid, res_sign, res_zero, res_man};
    last_in_ready = in_ready;
    acc           = in_valid && in_ready;
    if (acc) exp_q.push_back(model(int'(aligned_man), int'(big_man), big_sign, op_int, op_final));
    @(negedge clk);
  endtask

  // ---------------- drivers ----------------
  task automatic set_beat(input logic [AL_W-1:0] al, input logic [MAN_W-1:0] big,
                          input bit bs, input bit opi, input bit opf);
    aligned_man = al;
    big_man     = big;
    big_sign    = bs;
    op_int      = opi;
    op_final    = opf;
  endtask

  task automatic rand_beat();
    logic [MAN_W-1:0] b;
    b = MAN_W'($urandom_range(0, (1 << MAN_W) - 1));
    if ($urandom_range(0, 7) == 0) set_beat({b, 3'b000}, b, 1'($urandom), 1'($urandom), 1'($urandom));
    else set_beat(AL_W'($urandom_range(0, (1 << AL_W) - 1)), b, 1'($urandom), 1'($urandom), 1'($urandom));
  endtask

  // Present the current beat until it is taken; returns cycles used
  task automatic send(output int cycles);
    bit acc;
    in_valid = 1'b1;
    cycles = 0;
    acc = 1'b0;
    while (!acc && cycles < 50) begin
      step(acc);
      cycles++;
    end
    if (!acc) check("send_timeout", 32'd0, 32'd1);
    in_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    bit acc;
    in_valid = 1'b0;
    for (int i = 0; i < n; i++) step(acc);
  endtask

  task automatic drain();
    bit acc;
    int guard;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    guard = 0;
    while ((exp_q.size() != 0 || out_valid) && guard < 40) begin
      step(acc);
      guard++;
    end
    check("drain_empty", 32'(exp_q.size()), 32'd0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int  cyc_used;
    int  idx;
    bit  acc;
    logic [AL_W-1:0]  bp_al[4];
    logic [MAN_W-1:0] bp_big[4];

    // Reset state
    #1;
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_res_man", 32'(res_man), 32'd0);
    check("rst_res_sign", 32'(res_sign), 32'd0);
    check("rst_res_zero", 32'(res_zero), 32'd0);
`ifdef MANT_LZC_EN
    check("rst_res_lzc", 32'(res_lzc), 32'd0);
`endif
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    #1;
    check("rst_in_ready", 32'(in_ready), 32'd1);
    @(negedge clk);

    // Directed 1: add with 2-cycle latency
    out_ready = 1'b1;
    set_beat(14'h2000, 11'h400, 1'b1, 1'b0, 1'b0);
    send(cyc_used);
    check("lat_cycle1_out_valid", 32'(out_valid), 32'd0);
    idle(1);
    check("lat_cycle2_out_valid", 32'(out_valid), 32'd1);
    idle(1);

    // Directed 2..4: positive difference, negative difference, cancellation
    set_beat(14'h1000, 11'h400, 1'b1, 1'b0, 1'b1);
    send(cyc_used);
    set_beat(14'h3000, 11'h400, 1'b0, 1'b1, 1'b0);
    send(cyc_used);
    set_beat(14'h2000, 11'h400, 1'b1, 1'b0, 1'b1);
    send(cyc_used);
    drain();

    // Directed 5: backpressure with 4 beats, out_ready low for 3 cycles
    for (int i = 0; i < 4; i++) begin
      bp_al[i]  = AL_W'($urandom_range(0, (1 << AL_W) - 1));
      bp_big[i] = MAN_W'($urandom_range(0, (1 << MAN_W) - 1));
    end
    idx = 0;
    for (int c = 0; c < 30 && (idx < 4 || exp_q.size() != 0); c++) begin
      out_ready = (c >= 3);
      if (idx < 4) begin
        set_beat(bp_al[idx], bp_big[idx], 1'(idx), 1'(idx >> 1), 1'b1);
        in_valid = 1'b1;
      end else begin
        in_valid = 1'b0;
      end
      step(acc);
      if (c == 2) check("bp_in_ready_low", 32'(last_in_ready), 32'd0);
      if (acc) idx++;
    end
    in_valid = 1'b0;
    check("bp_all_sent", 32'(idx), 32'd4);
    drain();

    // Full throughput: each beat taken on its first cycle
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      rand_beat();
      send(cyc_used);
      check("throughput", 32'(cyc_used), 32'd1);
    end
    drain();

    // Directed 6: reset with 2 beats in flight
    out_ready = 1'b0;
    rand_beat();
    send(cyc_used);
    rand_beat();
    send(cyc_used);
    rst_n = 1'b0;
    #1;
    check("midrst_out_valid", 32'(out_valid), 32'd0);
    check("midrst_res_man", 32'(res_man), 32'd0);
    check("midrst_res_sign", 32'(res_sign), 32'd0);
    check("midrst_res_zero", 32'(res_zero), 32'd0);
    exp_q.delete();
    prev_stall = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    out_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      idle(1);
      check("post_rst_no_valid", 32'(out_valid), 32'd0);
      check("post_rst_in_ready", 32'(in_ready), 32'd1);
    end

    // Randomized traffic with random backpressure
    for (int c = 0; c < 400; c++) begin
      out_ready = ($urandom_range(0, 3) != 0);
      if (!in_valid || last_in_ready) begin
        if ($urandom_range(0, 3) != 0) begin
          rand_beat();
          in_valid = 1'b1;
        end else begin
          in_valid = 1'b0;
        end
      end
      step(acc);
      if (acc) in_valid = 1'b0;
    end
    drain();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
